charge_meter_display: RTL and testbench
=======================================

CHARGE_METER_DISPLAY -- requirements
Module: charge_meter_display

Interface
REQ-001 SHALL have parameter VAL_WIDTH, default 16, width of level input.
REQ-002 SHALL have parameter NUM_DIGITS, default 8, digits driven (legal 1..8).
REQ-003 SHALL have parameter STEP, default 55, level units per lit digit.
REQ-004 SHALL have parameter SCAN_DIV, default 5000, sys_clk cycles per scan tick.
REQ-005 SHALL have parameter BLINK_FRAMES, default 64, full scan frames per blink half-period.
REQ-006 SHALL have parameter PEAK_FRAMES, default 256, full scan frames per peak decay step.
REQ-007 SHALL have sys_clk, input, 1, clock; sys_rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have level, input, VAL_WIDTH, unsigned charge value.
REQ-009 SHALL have mode, input, 2, 0=bar fill, 1=single dot, 2=bar+peak hold, 3=blank.
REQ-010 SHALL have peak_clr, input, 1, single-cycle peak clear pulse.
REQ-011 SHALL have seg, output, 8, {CA,CB,CC,CD,CE,CF,CG,DP}, active-low.
REQ-012 SHALL have an, output, 8, digit enables, one-hot active-low.
REQ-013 SHALL have lit_cnt, output, 4, current quantised digit count (0..NUM_DIGITS).

Function
REQ-014 SHALL register level once; target = min(floor(level_q/STEP), NUM_DIGITS), computed by threshold compare, no divider.
REQ-015 SHALL move lit_cnt toward target by exactly 1 per sys_clk (up or down); equal -> hold; threshold register tracks lit_cnt*STEP with no wrap.
REQ-016 SHALL treat level >= NUM_DIGITS*STEP as saturated (target=NUM_DIGITS); level=0 -> target 0.
REQ-017 SHALL generate scan tick: single-cycle pulse every SCAN_DIV cycles; divider counter wraps to 0.
REQ-018 SHALL advance digit index on tick: 0..NUM_DIGITS-1, wrap to 0; frame_end pulse on wrap.
REQ-019 SHALL drive an[idx]=0, all other bits 1 (including bits >= NUM_DIGITS).
REQ-020 SHALL register seg and an in the same cycle so pattern and enable change together (zero skew).
REQ-021 Digit pattern: LIT=8'b0000_0001, PEAK=8'b1111_1110 (DP only), OFF=8'hFF.
REQ-022 Mode 0: digit idx LIT when idx < lit_cnt, else OFF.
REQ-023 Mode 1: digit idx LIT only when idx == lit_cnt-1; lit_cnt=0 -> all OFF.
REQ-024 Mode 2: as mode 0; additionally digit peak-1 shows PEAK when peak > lit_cnt.
REQ-025 Mode 3: all seg OFF; an keeps scanning.
REQ-026 Peak: peak <= lit_cnt whenever lit_cnt > peak (same cycle precedence over decay); decrement by 1 every PEAK_FRAMES frames when peak > lit_cnt; never below lit_cnt.
REQ-027 peak_clr SHALL set peak to lit_cnt next cycle, overriding rise and decay; restart decay counter.
REQ-028 Blink: when lit_cnt == NUM_DIGITS, LIT digits SHALL alternate LIT/OFF every BLINK_FRAMES frames, starting LIT; blink phase resets to LIT when lit_cnt drops below NUM_DIGITS.
REQ-029 Mode change SHALL take effect at the next scan tick; counters and peak unaffected.

Reset
REQ-030 On sys_rst_n low: lit_cnt=0, threshold=0, peak=0, idx=0, divider/frame/blink/decay counters=0, blink phase=LIT.
REQ-031 On reset: an=8'b1111_1110, seg=8'hFF.
REQ-032 Reset assertion mid-scan SHALL take effect immediately (asynchronous); first tick after release occurs SCAN_DIV cycles later.

Structure
REQ-033 Shared package SHALL hold mode encodings and LIT/PEAK/OFF segment constants.
REQ-034 One sub-module tick_gen (parameter DIV) SHALL produce the scan tick; instantiated once.
REQ-035 Total RTL 120-400 lines; no latches, single clock domain.

Verification (bench uses SCAN_DIV=4, BLINK_FRAMES=2, PEAK_FRAMES=2, NUM_DIGITS=8, STEP=55)
REQ-036 Reset release, level=0 -> an rotates FE,FD,FB,...,7F,FE every 4 cycles; seg=FF throughout.
REQ-037 Mode 0, level 0->170 -> lit_cnt steps 1,2,3 on consecutive cycles; digits 0-2 show 01, others FF.
REQ-038 Level 440 then 1000 -> lit_cnt 8; lit digits toggle 01/FF every 2 frames; level to 100 -> lit_cnt ramps 8..1, blink stops at LIT.
REQ-039 Mode 2, level 330 then 110 -> lit_cnt 2, peak 6; digit 5 shows FE; peak decays 6->5->4->3->2 every 2 frames; peak_clr mid-decay -> peak=2 next cycle.
REQ-040 Mode 1, level 220 -> only digit 3 shows 01; mode 3 -> seg FF, an still scanning.
REQ-041 Reset asserted mid-frame with lit_cnt=5 -> an=FE, seg=FF, lit_cnt=0 immediately.

Source files
------------

// File: rtl/charge_meter_display_pkg.sv
// Shared encodings for the charge meter display: display modes and segment patterns.
// Segment byte order is {CA,CB,CC,CD,CE,CF,CG,DP}, active-low.
package charge_meter_display_pkg;

  typedef enum logic [1:0] {
    ModeBar   = 2'd0,
    ModeDot   = 2'd1,
    ModePeak  = 2'd2,
    ModeBlank = 2'd3
  } mode_e;

  localparam logic [7:0] SEG_LIT  = 8'b0000_0001;
  localparam logic [7:0] SEG_PEAK = 8'b1111_1110;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  // Active-low one-hot digit enable for a 3-bit digit index.
  function automatic logic [7:0] an_onehot_n(input logic [2:0] idx);
    return ~(8'd1 << idx);
  endfunction

endpackage

// File: rtl/charge_meter_display_tick_gen.sv
// Scan tick generator: one-cycle pulse every DIV clocks, counter wraps to zero.
module tick_gen #(
  parameter int unsigned DIV = 5000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/charge_meter_display.sv
// Multiplexed bar-graph charge meter: quantises level into lit digits, scans the digits,
// and adds dot, peak-hold, blank and full-scale blink behaviour.
module charge_meter_display
  import charge_meter_display_pkg::*;
#(
  parameter int unsigned VAL_WIDTH    = 16,
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned STEP         = 55,
  parameter int unsigned SCAN_DIV     = 5000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned PEAK_FRAMES  = 256
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [VAL_WIDTH-1:0] level,
  input  logic [1:0]           mode,
  input  logic                 peak_clr,
  output logic [7:0]           seg,
  output logic [7:0]           an,
  output logic [3:0]           lit_cnt
);

  localparam int unsigned THR_W = $clog2((NUM_DIGITS + 1) * STEP + 1);
  localparam int unsigned CMP_W = ((VAL_WIDTH > THR_W) ? VAL_WIDTH : THR_W) + 1;
  localparam int unsigned BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned DW    = (PEAK_FRAMES > 1) ? $clog2(PEAK_FRAMES) : 1;

  localparam logic [CMP_W-1:0] STEP_W  = CMP_W'(STEP);
  localparam logic [3:0]       ND4     = 4'(NUM_DIGITS);
  localparam logic [2:0]       IDX_MAX = 3'(NUM_DIGITS - 1);

  logic [VAL_WIDTH-1:0] r_level;
  logic [CMP_W-1:0]     r_thr, w_thr_d, w_level_ext;
  logic [3:0]           r_lit, w_lit_d;
  logic [3:0]           r_peak, w_peak_d;
  logic [DW-1:0]        r_dcnt, w_dcnt_d;
  logic [BW-1:0]        r_bcnt, w_bcnt_d;
  logic                 r_boff, w_boff_d;
  logic [2:0]           r_idx, w_idx_d;
  logic [7:0]           r_seg, r_an, w_seg_d, w_lit_pat;
  logic [3:0]           w_idx4;
  logic                 w_tick, w_frame_end;

  tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .o_tick    (w_tick)
  );

  assign w_level_ext = CMP_W'(r_level);
  assign w_frame_end = w_tick && (r_idx == IDX_MAX);

  // Threshold tracks lit_cnt*STEP, so one compare per direction replaces a divider.
  always_comb begin
    w_lit_d = r_lit;
    w_thr_d = r_thr;
    if ((r_lit < ND4) && (w_level_ext >= r_thr + STEP_W)) begin
      w_lit_d = r_lit + 4'd1;
      w_thr_d = r_thr + STEP_W;
    end else if ((r_lit != 4'd0) && (w_level_ext < r_thr)) begin
      w_lit_d = r_lit - 4'd1;
      w_thr_d = r_thr - STEP_W;
    end
  end

  always_comb begin
    w_idx_d = r_idx;
    if (w_tick) begin
      w_idx_d = w_frame_end ? 3'd0 : r_idx + 3'd1;
    end
  end

  always_comb begin
    w_bcnt_d = r_bcnt;
    w_boff_d = r_boff;
    if (r_lit != ND4) begin
      w_bcnt_d = '0;
      w_boff_d = 1'b0;
    end else if (w_frame_end) begin
      if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
        w_bcnt_d = '0;
        w_boff_d = ~r_boff;
      end else begin
        w_bcnt_d = r_bcnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_peak_d = r_peak;
    w_dcnt_d = r_dcnt;
    if (peak_clr || (r_lit >= r_peak)) begin
      w_peak_d = r_lit;
      w_dcnt_d = '0;
    end else if (w_frame_end) begin
      if (r_dcnt == DW'(PEAK_FRAMES - 1)) begin
        w_peak_d = r_peak - 4'd1;
        w_dcnt_d = '0;
      end else begin
        w_dcnt_d = r_dcnt + 1'b1;
      end
    end
  end

  // Pattern uses next-state values so a whole frame sees one consistent state.
  always_comb begin
    w_seg_d   = SEG_OFF;
    w_idx4    = {1'b0, w_idx_d};
    w_lit_pat = ((w_lit_d == ND4) && w_boff_d) ? SEG_OFF : SEG_LIT;
    unique case (mode_e'(mode))
      ModeBar: begin
        if (w_idx4 < w_lit_d) w_seg_d = w_lit_pat;
      end
      ModeDot: begin
        if ((w_lit_d != 4'd0) && (w_idx4 == w_lit_d - 4'd1)) w_seg_d = w_lit_pat;
      end
      ModePeak: begin
        if (w_idx4 < w_lit_d) begin
          w_seg_d = w_lit_pat;
        end else if ((w_peak_d > w_lit_d) && (w_idx4 == w_peak_d - 4'd1)) begin
          w_seg_d = SEG_PEAK;
        end
      end
      ModeBlank: w_seg_d = SEG_OFF;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_level <= '0;
      r_thr   <= '0;
      r_lit   <= '0;
      r_peak  <= '0;
      r_dcnt  <= '0;
      r_bcnt  <= '0;
      r_boff  <= 1'b0;
      r_idx   <= '0;
      r_seg   <= SEG_OFF;
      r_an    <= 8'hFE;
    end else begin
      r_level <= level;
      r_thr   <= w_thr_d;
      r_lit   <= w_lit_d;
      r_peak  <= w_peak_d;
      r_dcnt  <= w_dcnt_d;
      r_bcnt  <= w_bcnt_d;
      r_boff  <= w_boff_d;
      r_idx   <= w_idx_d;
      if (w_tick) begin
        r_seg <= w_seg_d;
        r_an  <= an_onehot_n(w_idx_d);
      end
    end
  end

  assign seg     = r_seg;
  assign an      = r_an;
  assign lit_cnt = r_lit;

endmodule

// File: tb/tb_charge_meter_display.sv
// Directed bench for charge_meter_display with a fast scan (4 clocks per digit, 32 per frame).
module tb_charge_meter_display;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [15:0] level;
  logic [1:0]  mode;
  logic        peak_clr;
  logic [7:0]  seg, an;
  logic [3:0]  lit_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] AN_SEQ  = 64'h7FBF_DFEF_F7FB_FDFE;
  localparam logic [63:0] ALL_LIT = 64'h0101_0101_0101_0101;
  localparam logic [63:0] ALL_OFF = 64'hFFFF_FFFF_FFFF_FFFF;

  charge_meter_display #(
    .VAL_WIDTH    (16),
    .NUM_DIGITS   (8),
    .STEP         (55),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2),
    .PEAK_FRAMES  (2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .level     (level),
    .mode      (mode),
    .peak_clr  (peak_clr),
    .seg       (seg),
    .an        (an),
    .lit_cnt   (lit_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic sync_frame();
    logic [7:0] prev;
    bit ok;
    prev = an;
    ok   = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge sys_clk);
      if (an == 8'hFE && prev != 8'hFE) begin
        ok = 1'b1;
        break;
      end
      prev = an;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL sync_frame: no frame start in 80 cycles, an=%h required FE", an);
    end
  endtask

  task automatic capture_frame(output logic [63:0] segs, output logic [63:0] ans);
    sync_frame();
    segs = '0;
    ans  = '0;
    for (int d = 0; d < 8; d++) begin
      if (d != 0) repeat (4) @(negedge sys_clk);
      segs[d*8 +: 8] = seg;
      ans[d*8 +: 8]  = an;
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_an;
    sys_rst_n = 1'b0;
    level     = '0;
    mode      = 2'd0;
    peak_clr  = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    checks++;
    if (an !== 8'hFE || seg !== 8'hFF || lit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: an=%h seg=%h lit=%0d, required FE FF 0", an, seg, lit_cnt);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (an !== 8'hFE) begin
      errors++;
      $display("FAIL reset_first_tick_early: an=%h, required FE", an);
    end
    for (int k = 1; k <= 8; k++) begin
      repeat ((k == 1) ? 1 : 4) @(negedge sys_clk);
      exp_an = ~(8'd1 << (k % 8));
      checks++;
      if (an !== exp_an || seg !== 8'hFF) begin
        errors++;
        $display("FAIL reset_scan[%0d]: an=%h seg=%h, required %h FF", k, an, seg, exp_an);
      end
    end
  endtask

  task automatic test_bar();
    int exp_lit [5] = '{0, 1, 2, 3, 3};
    logic [63:0] f, a;
    mode  = 2'd0;
    level = 16'd170;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      checks++;
      if (lit_cnt !== 4'(exp_lit[i])) begin
        errors++;
        $display("FAIL bar_ramp[%0d]: lit=%0d, required %0d", i, lit_cnt, exp_lit[i]);
      end
    end
    capture_frame(f, a);
    checks++;
    if (f !== 64'hFFFF_FFFF_FF01_0101 || a !== AN_SEQ) begin
      errors++;
      $display("FAIL bar_frame: seg=%h an=%h, required FFFFFFFFFF010101 %h", f, a, AN_SEQ);
    end
  endtask

  task automatic test_blink();
    logic [63:0] f, a, exp_f;
    bit blink_lit [6] = '{1, 0, 0, 1, 1, 0};
    int exp_ramp [9] = '{8, 7, 6, 5, 4, 3, 2, 1, 1};
    sync_frame();
    level = 16'd440;
    repeat (8) @(negedge sys_clk);
    checks++;
    if (lit_cnt !== 4'd8) begin
      errors++;
      $display("FAIL blink_full: lit=%0d, required 8", lit_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 4) level = 16'd1000;
      capture_frame(f, a);
      exp_f = blink_lit[i] ? ALL_LIT : ALL_OFF;
      checks++;
      if (f !== exp_f) begin
        errors++;
        $display("FAIL blink_frame[%0d]: seg=%h, required %h", i, f, exp_f);
      end
    end
    level = 16'd100;
    for (int i = 0; i < 9; i++) begin
      @(negedge sys_clk);
      checks++;
      if (lit_cnt !== 4'(exp_ramp[i])) begin
        errors++;
        $display("FAIL blink_ramp_down[%0d]: lit=%0d, required %0d", i, lit_cnt, exp_ramp[i]);
      end
    end
    capture_frame(f, a);
    checks++;
    if (f !== 64'hFFFF_FFFF_FFFF_FF01) begin
      errors++;
      $display("FAIL blink_stopped: seg=%h, required FFFFFFFFFFFFFF01", f);
    end
  endtask

  task automatic test_peak();
    logic [63:0] f, a;
    logic [63:0] exp_f [6] = '{64'hFFFF_FEFF_FFFF_0101, 64'hFFFF_FFFE_FFFF_0101,
                               64'hFFFF_FFFE_FFFF_0101, 64'hFFFF_FFFF_FEFF_0101,
                               64'hFFFF_FFFF_FEFF_0101, 64'hFFFF_FFFF_FFFE_0101};
    mode  = 2'd2;
    level = 16'd330;
    repeat (10) @(negedge sys_clk);
    checks++;
    if (lit_cnt !== 4'd6) begin
      errors++;
      $display("FAIL peak_lit6: lit=%0d, required 6", lit_cnt);
    end
    peak_clr = 1'b1;
    @(negedge sys_clk);
    peak_clr = 1'b0;
    checks++;
    if (dut.r_peak !== 4'd6) begin
      errors++;
      $display("FAIL peak_clr_at6: peak=%0d, required 6", dut.r_peak);
    end
    sync_frame();
    level = 16'd110;
    for (int i = 0; i < 6; i++) begin
      capture_frame(f, a);
      checks++;
      if (f !== exp_f[i]) begin
        errors++;
        $display("FAIL peak_decay[%0d]: seg=%h, required %h", i, f, exp_f[i]);
      end
    end
    checks++;
    if (dut.r_peak !== 4'd3) begin
      errors++;
      $display("FAIL peak_before_clr: peak=%0d, required 3", dut.r_peak);
    end
    peak_clr = 1'b1;
    @(negedge sys_clk);
    peak_clr = 1'b0;
    checks++;
    if (dut.r_peak !== 4'd2) begin
      errors++;
      $display("FAIL peak_clr_mid_decay: peak=%0d, required 2", dut.r_peak);
    end
    for (int i = 0; i < 2; i++) begin
      capture_frame(f, a);
      checks++;
      if (f !== 64'hFFFF_FFFF_FFFF_0101) begin
        errors++;
        $display("FAIL peak_cleared[%0d]: seg=%h, required FFFFFFFFFFFF0101", i, f);
      end
    end
  endtask

  task automatic test_dot_blank();
    logic [63:0] f, a;
    mode  = 2'd1;
    level = 16'd220;
    repeat (10) @(negedge sys_clk);
    checks++;
    if (lit_cnt !== 4'd4) begin
      errors++;
      $display("FAIL dot_lit4: lit=%0d, required 4", lit_cnt);
    end
    capture_frame(f, a);
    checks++;
    if (f !== 64'hFFFF_FFFF_01FF_FFFF || a !== AN_SEQ) begin
      errors++;
      $display("FAIL dot_frame: seg=%h an=%h, required FFFFFFFF01FFFFFF %h", f, a, AN_SEQ);
    end
    mode = 2'd3;
    capture_frame(f, a);
    checks++;
    if (f !== ALL_OFF || a !== AN_SEQ) begin
      errors++;
      $display("FAIL blank_frame: seg=%h an=%h, required %h %h", f, a, ALL_OFF, AN_SEQ);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    mode  = 2'd0;
    level = 16'd275;
    repeat (10) @(negedge sys_clk);
    checks++;
    if (lit_cnt !== 4'd5) begin
      errors++;
      $display("FAIL rstmid_lit5: lit=%0d, required 5", lit_cnt);
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (an == 8'hFB) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || seg !== 8'h01) begin
      errors++;
      $display("FAIL rstmid_digit2: an=%h seg=%h, required FB 01", an, seg);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 8'hFE || seg !== 8'hFF || lit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_async: an=%h seg=%h lit=%0d, required FE FF 0", an, seg, lit_cnt);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (an !== 8'hFE) begin
      errors++;
      $display("FAIL rstmid_tick_early: an=%h, required FE", an);
    end
    @(negedge sys_clk);
    checks++;
    if (an !== 8'hFD) begin
      errors++;
      $display("FAIL rstmid_first_tick: an=%h, required FD", an);
    end
  endtask

  initial begin
    test_reset();
    test_bar();
    test_blink();
    test_peak();
    test_dot_blank();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
